// File: rtl/start_sequencer_pkg.sv
// Shared state encoding and run-length arithmetic for the start sequencer and its bench.
package start_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Cycles spent in RUN for one counter run: 2^w ticks at one per (d+1) cycles, plus the End cycle.
    function automatic int unsigned run_len(input int unsigned w, input int unsigned d);
        return (32'd1 << w) * (d + 32'd1) + 32'd1;
    endfunction

endpackage

// File: rtl/start_sequencer_tick_divider.sv
// Prescaler: Tick fires when the count equals Div, then the count wraps to zero.
module tick_divider #(
    parameter int pwidth = 8
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Clear,
    input  logic              En,
    input  logic [pwidth-1:0] Div,
    output logic              Tick
);

    logic [pwidth-1:0] cnt;

    assign Tick = En && (cnt == Div);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)
            cnt <= '0;
        else if (Clear)
            cnt <= '0;
        else if (En)
            cnt <= Tick ? '0 : cnt + pwidth'(1);
    end

endmodule

// File: rtl/start_sequencer.sv
// Burst sequencer driving a downstream start counter: launches N prescaled counter runs per request.
module start_sequencer
    import start_sequencer_pkg::*;
#(
    parameter int width  = 4,
    parameter int pwidth = 8,
    parameter int bwidth = 4
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              Req,
    input  logic [pwidth-1:0] Div,
    input  logic [bwidth-1:0] Burst,
    input  logic              Abort,
    input  logic              CntEnd,
    input  logic              CntBusy,
    output logic              Start,
    output logic              CountEn,
    output logic              Ack,
    output logic              Done,
    output logic              Active,
    output logic [bwidth-1:0] Remaining,
    output logic              Error
);

    state_t            state, state_nxt;
    logic [pwidth-1:0] div_q;
    logic [bwidth-1:0] burst_q;
    logic [bwidth-1:0] rem_q;
    logic [bwidth-1:0] rem_dec;
    logic              ack_q;
    logic              err_q;
    logic              tick;
    logic              accept;
    logic [31:0]       run_cyc;
    logic [31:0]       run_exp;

    assign accept  = (state == ST_IDLE) && Req && !Abort && !CntBusy;
    assign rem_dec = rem_q - bwidth'(1);

    // LAUNCH always precedes RUN, so holding the prescaler clear outside RUN clears it on entry.
    tick_divider #(.pwidth(pwidth)) u_div (
        .Clock  (Clock),
        .ResetN (ResetN),
        .Clear  (state != ST_RUN),
        .En     (state == ST_RUN),
        .Div    (div_q),
        .Tick   (tick)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = (Burst == '0) ? ST_DONE : ST_LAUNCH;
            ST_LAUNCH: state_nxt = Abort ? ST_DRAIN : ST_RUN;
            ST_RUN: begin
                if (CntEnd) begin
                    if (Abort)
                        state_nxt = ST_IDLE;
                    else
                        state_nxt = (rem_dec == '0) ? ST_DONE : ST_LAUNCH;
                end else if (!CntBusy) begin
                    state_nxt = ST_IDLE;
                end else if (Abort) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN:  if (CntEnd) state_nxt = ST_IDLE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Start   = 1'b0;
        CountEn = 1'b0;
        Done    = 1'b0;
        Active  = 1'b1;
        case (state)
            ST_IDLE:   Active  = 1'b0;
            ST_LAUNCH: Start   = 1'b1;
            ST_RUN:    CountEn = tick;
            ST_DRAIN:  CountEn = 1'b1;
            ST_DONE:   Done    = 1'b1;
            default:   Active  = 1'b0;
        endcase
    end

    // A counter that stops responding (no End, no Busy) mid-run is a protocol error.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            div_q   <= '0;
            burst_q <= '0;
            rem_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                div_q   <= Div;
                burst_q <= Burst;
                rem_q   <= Burst;
                err_q   <= 1'b0;
            end else begin
                case (state)
                    ST_LAUNCH: if (Abort) rem_q <= '0;
                    ST_RUN: begin
                        if (CntEnd)
                            rem_q <= Abort ? '0 : rem_dec;
                        else if (!CntBusy)
                            err_q <= 1'b1;
                        else if (Abort)
                            rem_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)
            run_cyc <= '0;
        else if (state == ST_RUN)
            run_cyc <= run_cyc + 32'd1;
        else
            run_cyc <= '0;
    end

    assign run_exp   = run_len(width, 32'(div_q));
    assign Ack       = ack_q;
    assign Remaining = rem_q;
    assign Error     = err_q;

    // A well-behaved counter ends exactly on the last cycle of the nominal run.
    a_run_len: assert property (@(posedge Clock) disable iff (!ResetN)
        (state == ST_RUN && CntEnd) |-> (run_cyc + 32'd1 == run_exp));

    a_rem_bound: assert property (@(posedge Clock) disable iff (!ResetN)
        rem_q <= burst_q);

endmodule

// File: tb/tb_start_sequencer.sv
// Randomized scoreboard bench for start_sequencer with a behavioural downstream counter.
module tb_start_sequencer;
    import start_sequencer_pkg::*;

    localparam int W = 4;
    localparam int EV_ACK = 0, EV_START = 1, EV_DONE = 2, EV_END = 3;

    typedef struct {
        int kind;
        int cyc;
        int rem;
        int err;
        int cen;
    } ev_t;

    logic       Clock, ResetN, Req, Abort, CntEnd, CntBusy;
    logic [7:0] Div;
    logic [3:0] Burst;
    logic       Start, CountEn, Ack, Done, Active, Error;
    logic [3:0] Remaining;

    logic busy, end_r, kill;
    int   ccnt;
    int   cyc = 0;
    int   checks = 0, errors = 0;
    int   cen_cnt = 0;
    logic prev_active = 1'b0;
    ev_t  q[$];

    start_sequencer #(.width(W), .pwidth(8), .bwidth(4)) dut (
        .Clock(Clock), .ResetN(ResetN), .Req(Req), .Div(Div), .Burst(Burst),
        .Abort(Abort), .CntEnd(CntEnd), .CntBusy(CntBusy), .Start(Start),
        .CountEn(CountEn), .Ack(Ack), .Done(Done), .Active(Active),
        .Remaining(Remaining), .Error(Error)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    // Downstream counter: Start arms it, 2^W CountEn ticks later it pulses End; kill models a dead counter.
    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            busy <= 1'b0; end_r <= 1'b0; ccnt <= 0;
        end else begin
            end_r <= 1'b0;
            if (kill) busy <= 1'b0;
            else if (Start) begin busy <= 1'b1; ccnt <= 0; end
            else if (busy && CountEn) begin
                if (ccnt == (1 << W) - 1) begin busy <= 1'b0; end_r <= 1'b1; end
                else ccnt <= ccnt + 1;
            end
        end
    end
    assign CntEnd  = end_r;
    assign CntBusy = busy && !kill;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic void push(input int kind, input int c, input int rem, input int err, input int cen);
        ev_t e;
        e.kind = kind; e.cyc = c; e.rem = rem; e.err = err; e.cen = cen;
        q.push_back(e);
    endfunction

    task automatic take(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d (none expected)", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == e.kind) begin
                case (kind)
                    EV_ACK: begin
                        chk("ack_remaining", int'(Remaining), e.rem);
                        chk("ack_error_cleared", int'(Error), 0);
                        chk("ack_active", int'(Active), 1);
                    end
                    EV_START: chk("start_remaining", int'(Remaining), e.rem);
                    EV_DONE:  chk("done_remaining", int'(Remaining), 0);
                    default: begin
                        chk("end_error", int'(Error), e.err);
                        if (e.rem >= 0) chk("end_remaining", int'(Remaining), e.rem);
                        chk("end_count_en_total", cen_cnt, e.cen);
                    end
                endcase
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge Clock);
            if (!ResetN) begin
                prev_active = 1'b0;
            end else begin
                if (Ack) begin take(EV_ACK); cen_cnt = 0; end
                if (CountEn) cen_cnt++;
                if (Start) take(EV_START);
                if (Done) take(EV_DONE);
                if (prev_active && !Active) take(EV_END);
                prev_active = Active;
            end
        end
    end

    // Plans: 0 full burst, 1 abort at RUN offset r of run k (r=-1 is LAUNCH),
    // 2 counter dies at RUN offset r of run k, 3 abort coinciding with End of run k.
    task automatic push_burst(input int ack, input int d, input int n, input int plan,
                              input int k, input int r, output int act, output int idle);
        int full, L, per, ns, runst, t;
        full  = 1 << W;
        L     = int'(run_len(W, d));
        per   = full + ((d == 0) ? 1 : 0);
        ns    = (plan == 0) ? n : k;
        runst = ack + (k - 1) * (L + 1) + 1;
        push(EV_ACK, ack, n, 0, 0);
        for (int j = 1; j <= ns; j++) push(EV_START, ack + (j - 1) * (L + 1), n - j + 1, 0, 0);
        if (plan == 0) begin
            act  = ack + n * (L + 1);
            idle = act + 1;
            push(EV_DONE, act, 0, 0, 0);
            push(EV_END, idle, 0, 0, n * per);
        end else if (plan == 1) begin
            act  = runst + r;
            t    = (r < 0) ? 0 : (r + 1) / (d + 1);
            idle = act + 1 + (full - t) + 1;
            push(EV_END, idle, 0, 0, per * (k - 1) + full + 1);
        end else if (plan == 2) begin
            act  = runst + r;
            idle = act + 1;
            push(EV_END, idle, n - k + 1, 1, per * (k - 1) + (r + 1) / (d + 1));
        end else begin
            act  = runst + L - 1;
            idle = act + 1;
            push(EV_END, idle, -1, 0, per * k);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (q.size() != 0 && t < 40) begin @(negedge Clock); t++; end
        chk("scoreboard_drained", q.size(), 0);
        q.delete();
        @(negedge Clock);
    endtask

    task automatic do_burst(input int d, input int n, input int plan, input int k, input int r);
        int ack, act, idle;
        Req = 1'b1; Div = 8'(d); Burst = 4'(n);
        ack = cyc + 1;
        push_burst(ack, d, n, plan, k, r, act, idle);
        @(negedge Clock);
        while (cyc < idle) begin
            Req  = ($urandom_range(0, 3) == 0);
            kill = (plan == 2 && cyc == act);
            if (plan == 1)      Abort = (cyc == act) || (cyc > act && $urandom_range(0, 1) == 1);
            else if (plan == 3) Abort = (cyc == act);
            else if (plan == 0) Abort = (cyc == act) && ($urandom_range(0, 1) == 1);
            else                Abort = 1'b0;
            @(negedge Clock);
        end
        Req = 1'b0; Abort = 1'b0; kill = 1'b0;
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int d, n, p, k, r, L, plan, ack, act, idle, act2, idle2;
        Req = 1'b0; Div = '0; Burst = '0; Abort = 1'b0; kill = 1'b0;
        ResetN = 1'b1;
        #1 ResetN = 1'b0;
        #1 chk("reset_outputs", int'({Start, CountEn, Ack, Done, Active, Remaining, Error}), 0);
        repeat (2) @(negedge Clock);
        #2 ResetN = 1'b1;
        @(negedge Clock);

        do_burst(0, 2, 0, 1, 0);     // Start c1/c19, Done c37
        do_burst(3, 1, 0, 1, 0);     // Done 66 cycles after Ack
        do_burst(0, 0, 0, 1, 0);     // empty burst
        do_burst(0, 3, 1, 1, 4);     // abort after 5 ticks, drain
        do_burst(1, 2, 1, 2, -1);    // abort in LAUNCH of run 2
        do_burst(0, 1, 2, 1, 0);     // counter dies on first RUN cycle
        do_burst(2, 2, 0, 1, 0);     // Error cleared by this Ack
        do_burst(0, 2, 3, 2, 0);     // abort together with End

        // Req held high across Done is re-accepted on the first IDLE edge.
        Req = 1'b1; Div = 8'd0; Burst = 4'd1;
        ack = cyc + 1;
        push_burst(ack, 0, 1, 0, 1, 0, act, idle);
        push_burst(idle + 1, 0, 1, 0, 1, 0, act2, idle2);
        while (cyc < idle + 1) @(negedge Clock);
        Req = 1'b0;
        while (cyc < idle2) @(negedge Clock);
        wait_drain();

        // Reset mid-RUN: outputs drop at once, no Done, fresh request accepted after release.
        Req = 1'b1; Div = 8'd0; Burst = 4'd2;
        ack = cyc + 1;
        push_burst(ack, 0, 2, 0, 1, 0, act, idle);
        @(negedge Clock);
        Req = 1'b0;
        repeat (8) @(negedge Clock);
        #2 ResetN = 1'b0;
        q.delete();
        #1 chk("async_reset_outputs", int'({Start, CountEn, Ack, Done, Active, Remaining, Error}), 0);
        @(negedge Clock);
        #2 ResetN = 1'b1;
        @(negedge Clock);
        do_burst(1, 1, 0, 1, 0);

        for (int i = 0; i < 25; i++) begin
            d = $urandom_range(0, 3);
            n = $urandom_range(0, 3);
            p = $urandom_range(0, 9);
            L = int'(run_len(W, d));
            k = 1; r = 0; plan = 0;
            if (n != 0 && p >= 4) begin
                k = $urandom_range(1, n);
                if (p < 7)      begin plan = 1; r = int'($urandom_range(0, L - 1)) - 1; end
                else if (p < 9) begin plan = 2; r = int'($urandom_range(0, L - 2)); end
                else            plan = 3;
            end
            do_burst(d, n, plan, k, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter width, default 4: bit width of the downstream start counter; one counter run = 2^width CountEn ticks.
REQ-002 Parameter pwidth, default 8: prescale divisor width.
REQ-003 Parameter bwidth, default 4: burst length width.
REQ-004 Clock  in  1  single clock; all logic on rising edge.
REQ-005 ResetN  in  1  asynchronous, active-low reset.
REQ-006 Req  in  1  level request; sampled only in IDLE.
REQ-007 Div  in  pwidth  prescale divisor D, latched at accept.
REQ-008 Burst  in  bwidth  number of counter runs N, latched at accept.
REQ-009 Abort  in  1  level; terminates the burst early.
REQ-010 CntEnd  in  1  End pulse from the downstream start counter.
REQ-011 CntBusy  in  1  Busy from the downstream start counter.
REQ-012 Start  out  1  start pulse to the counter.
REQ-013 CountEn  out  1  prescaled count enable to the counter.
REQ-014 Ack  out  1  one-cycle accept pulse.
REQ-015 Done  out  1  one-cycle burst-complete pulse.
REQ-016 Active  out  1  high in any state other than IDLE.
REQ-017 Remaining  out  bwidth  runs still to complete.
REQ-018 Error  out  1  sticky protocol-error flag.

Function
REQ-019 FSM states SHALL be IDLE, LAUNCH, RUN, DRAIN and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-020 Accept: IDLE with Req=1, Abort=0 and CntBusy=0 at an edge SHALL latch Div and Burst, load Remaining=Burst, clear Error, and assert Ack for the next cycle.
REQ-021 After an accept with Burst=0, the FSM SHALL go to DONE with no Start issued; otherwise it SHALL go to LAUNCH.
REQ-022 LAUNCH SHALL last 1 cycle with Start=1, then enter RUN.
REQ-023 RUN prescaler: counter cleared on RUN entry; CountEn=1 on each cycle where the prescaler equals D, which also wraps the prescaler to 0. D=0 gives CountEn every cycle.
REQ-024 CountEn SHALL be 0 in IDLE, LAUNCH and DONE.
REQ-025 RUN with CntEnd=1: Remaining SHALL decrement; the FSM goes to DONE if the result is 0, else to LAUNCH.
REQ-026 RUN with CntEnd=0 and CntBusy=0: Error SHALL be set and the FSM returns to IDLE with no Done.
REQ-027 Run length: RUN SHALL last 2^width*(D+1)+1 cycles, and Done SHALL be asserted N*(2^width*(D+1)+2) cycles after Ack.
REQ-028 DONE SHALL last 1 cycle with Done=1, then return to IDLE; Abort in DONE SHALL be ignored.
REQ-029 Abort in LAUNCH, or in RUN without CntEnd, SHALL enter DRAIN and clear Remaining.
REQ-030 Abort in RUN with CntEnd=1 in the same cycle SHALL go directly to IDLE with no Done.
REQ-031 DRAIN SHALL hold CountEn=1 every cycle until CntEnd, then go to IDLE with no Done; Abort and Req SHALL be ignored in DRAIN.
REQ-032 Req outside IDLE SHALL be ignored with no Ack; Req held high after Done SHALL be re-accepted on the first IDLE edge.

Reset
REQ-033 ResetN low SHALL immediately force the state to IDLE and clear Start, CountEn, Ack, Done, Active, Remaining, Error, the prescaler and the latched Div and Burst.
REQ-034 Reset mid-burst SHALL NOT pulse Done; the downstream counter is reset by the same ResetN.
REQ-035 ResetN deassertion SHALL be synchronised to Clock outside this block.

Structure
REQ-036 The state encoding and the run-length expression 2^width*(D+1)+1 SHALL live in a shared constants include, also used by the bench.
REQ-037 The prescaler SHALL be a sub-module tick_divider (ports: Clock, ResetN, Clear, En, Div, Tick).

Verification
REQ-038 width=4, D=0, N=2, Req pulsed: Ack at c1; Start at c1 and c19; CntEnd at c18 and c36; Done at c37; Remaining goes 2 then 1 then 0.
REQ-039 D=3, N=1: CountEn every 4th RUN cycle, 16 ticks, Done exactly 66 cycles after Ack.
REQ-040 N=0: Ack, then Done on the next cycle; Start never asserted; CountEn stays 0.
REQ-041 Abort after 5 ticks of run 1 with N=3: DRAIN, CountEn every cycle for 11 cycles, CntEnd, IDLE; no Done; Remaining=0.
REQ-042 CntBusy forced 0 in the first RUN cycle: Error=1 and IDLE; Error cleared by the next Ack.
REQ-043 ResetN pulsed low mid-RUN: all outputs 0 asynchronously; a fresh Req is accepted normally after release.
